// File: rtl/csi2tx_dphy_esc_rx_clk_rec.sv
// Multi-lane LP escape-mode clock/data recovery: per-lane sync, glitch filter,
// spaced-one-hot decoder with stop/error/timeout strobes and registered XOR clock.
module csi2tx_dphy_esc_rx_clk_rec #(
  parameter int NUM_LANES = 4,
  parameter int FILT_CYC  = 2,
  parameter int TOUT_CYC  = 1024
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [NUM_LANES-1:0] lane_en,
  input  logic [NUM_LANES-1:0] lp_rx_dp,
  input  logic [NUM_LANES-1:0] lp_rx_dn,
  output logic [NUM_LANES-1:0] rxclkesc,
  output logic [NUM_LANES-1:0] esc_bit_vld,
  output logic [NUM_LANES-1:0] esc_bit,
  output logic [NUM_LANES-1:0] esc_stop,
  output logic [NUM_LANES-1:0] esc_err,
  output logic [NUM_LANES-1:0] esc_tout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SPACE = 2'd1;
  localparam logic [1:0] S_MARK  = 2'd2;

  localparam int          TW     = (TOUT_CYC > 0) ? $clog2(TOUT_CYC + 1) : 1;
  localparam logic [TW:0] C_TOUT = (TW + 1)'(TOUT_CYC);
  // The filter count is cleared on the edge that loads a new sync value, so
  // a value held FILT_CYC edges has reached FILT_CYC-1.
  localparam logic [3:0]  C_FTH  = 4'(FILT_CYC - 1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [1:0]    r_s1;
      logic [1:0]    r_s2;
      logic [1:0]    r_filt;
      logic [1:0]    r_filt_d;
      logic [1:0]    r_state;
      logic [3:0]    r_fcnt;
      logic [TW-1:0] r_tcnt;
      logic          r_clk;
      logic          r_vld;
      logic          r_bit;
      logic          r_stop;
      logic          r_err;
      logic          r_tout;

      logic          w_rst;
      logic          w_chg;
      logic          w_tout_hit;
      logic [TW:0]   w_tinc;
      logic [1:0]    w_state_next;
      logic [TW-1:0] w_tcnt_next;
      logic          w_vld_next;
      logic          w_bit_next;
      logic          w_stop_next;
      logic          w_err_next;
      logic          w_tout_next;

      assign w_rst      = sys_rst | ~lane_en[gi];
      assign w_chg      = (r_filt != r_filt_d);
      assign w_tinc     = {1'b0, r_tcnt} + (TW + 1)'(1);
      assign w_tout_hit = (TOUT_CYC != 0) && (w_tinc == C_TOUT);

      always_comb begin
        w_state_next = r_state;
        w_tcnt_next  = r_tcnt;
        w_vld_next   = 1'b0;
        w_bit_next   = r_bit;
        w_stop_next  = 1'b0;
        w_err_next   = 1'b0;
        w_tout_next  = 1'b0;
        // A line change always wins over a coincident terminal count.
        if (w_chg) begin
          w_tcnt_next = '0;
          case (r_state)
            S_IDLE: begin
              if (r_filt == 2'b00) w_state_next = S_SPACE;
            end
            S_SPACE: begin
              case (r_filt)
                2'b10: begin
                  w_state_next = S_MARK;
                  w_vld_next   = 1'b1;
                  w_bit_next   = 1'b1;
                end
                2'b01: begin
                  w_state_next = S_MARK;
                  w_vld_next   = 1'b1;
                  w_bit_next   = 1'b0;
                end
                2'b11: begin
                  w_state_next = S_IDLE;
                  w_stop_next  = 1'b1;
                end
                default: ;
              endcase
            end
            S_MARK: begin
              case (r_filt)
                2'b00: w_state_next = S_SPACE;
                2'b11: begin
                  w_state_next = S_IDLE;
                  w_stop_next  = 1'b1;
                end
                default: begin
                  w_state_next = S_IDLE;
                  w_err_next   = 1'b1;
                end
              endcase
            end
            default: w_state_next = S_IDLE;
          endcase
        end else if (r_state == S_IDLE) begin
          w_tcnt_next = '0;
        end else if (w_tout_hit) begin
          w_tcnt_next  = '0;
          w_state_next = S_IDLE;
          w_tout_next  = 1'b1;
        end else begin
          w_tcnt_next = w_tinc[TW-1:0];
        end
      end

      always_ff @(posedge sys_clk) begin
        if (w_rst) begin
          r_s1     <= 2'b11;
          r_s2     <= 2'b11;
          r_filt   <= 2'b11;
          r_filt_d <= 2'b11;
          r_fcnt   <= '0;
          r_state  <= S_IDLE;
          r_tcnt   <= '0;
          r_clk    <= 1'b0;
          r_vld    <= 1'b0;
          r_bit    <= 1'b0;
          r_stop   <= 1'b0;
          r_err    <= 1'b0;
          r_tout   <= 1'b0;
        end else begin
          r_s1 <= {lp_rx_dp[gi], lp_rx_dn[gi]};
          r_s2 <= r_s1;
          if (r_s1 != r_s2) begin
            r_fcnt <= '0;
          end else if (r_fcnt != 4'hF) begin
            r_fcnt <= r_fcnt + 4'd1;
          end
          if ((r_s2 != r_filt) && (r_fcnt >= C_FTH)) begin
            r_filt <= r_s2;
          end
          r_filt_d <= r_filt;
          r_state  <= w_state_next;
          r_tcnt   <= w_tcnt_next;
          r_clk    <= r_filt[1] ^ r_filt[0];
          r_vld    <= w_vld_next;
          r_bit    <= w_bit_next;
          r_stop   <= w_stop_next;
          r_err    <= w_err_next;
          r_tout   <= w_tout_next;
        end
      end

      assign rxclkesc[gi]    = r_clk;
      assign esc_bit_vld[gi] = r_vld;
      assign esc_bit[gi]     = r_bit;
      assign esc_stop[gi]    = r_stop;
      assign esc_err[gi]     = r_err;
      assign esc_tout[gi]    = r_tout;
    end
  endgenerate

endmodule

// File: tb/tb_csi2tx_dphy_esc_rx_clk_rec.sv
// Directed bench for the escape-mode clock/data recovery block (4 lanes,
// FILT_CYC=2, TOUT_CYC=16); expected strobe cycles are hand-derived.
module tb_csi2tx_dphy_esc_rx_clk_rec;

  localparam int NL      = 4;
  localparam int NB      = 220;
  localparam int EV_B0   = 0;
  localparam int EV_B1   = 1;
  localparam int EV_STOP = 2;
  localparam int EV_ERR  = 3;
  localparam int EV_TOUT = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic [NL-1:0] lane_en;
  logic [NL-1:0] lp_rx_dp;
  logic [NL-1:0] lp_rx_dn;
  logic [NL-1:0] rxclkesc;
  logic [NL-1:0] esc_bit_vld;
  logic [NL-1:0] esc_bit;
  logic [NL-1:0] esc_stop;
  logic [NL-1:0] esc_err;
  logic [NL-1:0] esc_tout;

  int          n_cmp   = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  int          n_multi = 0;
  int          ev_n[NL];
  int          ev_typ[NL][512];
  int          ev_cyc[NL][512];
  int          got_n[NL];
  bit          got_bit[NL][256];
  bit          exp_bit[NL][256];
  int          n_stop[NL];
  int          n_err[NL];
  int          n_tout[NL];
  int          nz[NL];
  int          clk_n[NL];
  logic [31:0] clk_hist[NL];
  logic        clk_prev[NL];
  int          ph_left[NL];
  int          ph_idx[NL];
  logic [1:0]  rv;
  bit          done;
  int          t0;
  int          sum;

  csi2tx_dphy_esc_rx_clk_rec #(
    .NUM_LANES(NL),
    .FILT_CYC (2),
    .TOUT_CYC (16)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .lane_en    (lane_en),
    .lp_rx_dp   (lp_rx_dp),
    .lp_rx_dn   (lp_rx_dn),
    .rxclkesc   (rxclkesc),
    .esc_bit_vld(esc_bit_vld),
    .esc_bit    (esc_bit),
    .esc_stop   (esc_stop),
    .esc_err    (esc_err),
    .esc_tout   (esc_tout)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic log_ev(input int l, input int typ);
    if (ev_n[l] < 512) begin
      ev_typ[l][ev_n[l]] = typ;
      ev_cyc[l][ev_n[l]] = cyc;
    end
    ev_n[l]++;
  endtask

  task automatic clear_log();
    for (int l = 0; l < NL; l++) begin
      ev_n[l]     = 0;
      got_n[l]    = 0;
      n_stop[l]   = 0;
      n_err[l]    = 0;
      n_tout[l]   = 0;
      nz[l]       = 0;
      clk_n[l]    = 0;
      clk_hist[l] = '0;
      for (int k = 0; k < 512; k++) begin
        ev_typ[l][k] = 99;
        ev_cyc[l][k] = -1;
      end
    end
  endtask

  // One clock: sample 1 time unit after the edge and log every strobe.
  task automatic step();
    int nh;
    @(posedge sys_clk);
    #1;
    cyc++;
    for (int l = 0; l < NL; l++) begin
      nh = int'(esc_bit_vld[l]) + int'(esc_stop[l]) + int'(esc_err[l]) + int'(esc_tout[l]);
      if (nh > 1) n_multi++;
      if (esc_bit_vld[l]) begin
        log_ev(l, esc_bit[l] ? EV_B1 : EV_B0);
        if (got_n[l] < 256) got_bit[l][got_n[l]] = esc_bit[l];
        got_n[l]++;
      end
      if (esc_stop[l]) begin
        log_ev(l, EV_STOP);
        n_stop[l]++;
      end
      if (esc_err[l]) begin
        log_ev(l, EV_ERR);
        n_err[l]++;
      end
      if (esc_tout[l]) begin
        log_ev(l, EV_TOUT);
        n_tout[l]++;
      end
      if (rxclkesc[l] != clk_prev[l]) begin
        clk_hist[l] = {clk_hist[l][30:0], rxclkesc[l]};
        clk_n[l]++;
        clk_prev[l] = rxclkesc[l];
      end
      if ({rxclkesc[l], esc_bit_vld[l], esc_bit[l], esc_stop[l], esc_err[l], esc_tout[l]} != 6'b0)
        nz[l]++;
    end
  endtask

  task automatic phase(input logic [NL-1:0] m, input logic [1:0] v, input int n);
    for (int l = 0; l < NL; l++) begin
      if (m[l]) begin
        lp_rx_dp[l] = v[1];
        lp_rx_dn[l] = v[0];
      end
    end
    repeat (n) step();
  endtask

  task automatic chk_ev(input string tag, input int l, input int idx, input int typ, input int c);
    check_val($sformatf("%s_type", tag), ev_typ[l][idx], typ);
    check_val($sformatf("%s_cyc", tag), ev_cyc[l][idx], c);
  endtask

  task automatic chk_outs_zero(input string tag);
    check_val($sformatf("%s_rxclkesc", tag), int'(rxclkesc), 0);
    check_val($sformatf("%s_vld", tag), int'(esc_bit_vld), 0);
    check_val($sformatf("%s_bit", tag), int'(esc_bit), 0);
    check_val($sformatf("%s_stop", tag), int'(esc_stop), 0);
    check_val($sformatf("%s_err", tag), int'(esc_err), 0);
    check_val($sformatf("%s_tout", tag), int'(esc_tout), 0);
  endtask

  initial begin
    for (int l = 0; l < NL; l++) clk_prev[l] = 1'b0;
    clear_log();
    sys_rst  = 1'b1;
    lane_en  = '1;
    lp_rx_dp = '0;
    lp_rx_dn = '0;

    // Reset with lines at 00, then idle at 11 for 100 cycles.
    repeat (3) step();
    chk_outs_zero("rst");
    lp_rx_dp = '1;
    lp_rx_dn = '1;
    sys_rst  = 1'b0;
    clear_log();
    repeat (100) step();
    sum = 0;
    for (int l = 0; l < NL; l++) sum += ev_n[l] + nz[l];
    check_val("idle_quiet", sum, 0);

    // Decode: Mark-1, Mark-0, stop; each strobe 5 edges after its change.
    clear_log();
    t0 = cyc;
    phase(4'b0001, 2'b00, 6);
    phase(4'b0001, 2'b10, 6);
    phase(4'b0001, 2'b00, 6);
    phase(4'b0001, 2'b01, 6);
    phase(4'b0001, 2'b00, 6);
    phase(4'b0001, 2'b11, 6);
    check_val("dec_nev", ev_n[0], 3);
    chk_ev("dec_b1", 0, 0, EV_B1, t0 + 11);
    chk_ev("dec_b0", 0, 1, EV_B0, t0 + 23);
    chk_ev("dec_stop", 0, 2, EV_STOP, t0 + 35);
    check_val("dec_clk_n", clk_n[0], 4);
    check_val("dec_clk_seq", int'(clk_hist[0][3:0]), 4'b1010);

    // Glitch: 1-cycle pulse rejected, 2-cycle pulse decoded.
    clear_log();
    phase(4'b0001, 2'b00, 6);
    phase(4'b0001, 2'b10, 1);
    phase(4'b0001, 2'b00, 4);
    check_val("glitch1_nev", ev_n[0], 0);
    t0 = cyc;
    phase(4'b0001, 2'b10, 2);
    phase(4'b0001, 2'b00, 6);
    check_val("glitch2_nev", ev_n[0], 1);
    chk_ev("glitch2_b1", 0, 0, EV_B1, t0 + 5);
    phase(4'b0001, 2'b11, 6);
    check_val("glitch_stop", ev_typ[0][1], EV_STOP);

    // Error: Mark-1 straight to Mark-0, then 00 from IDLE gives nothing.
    clear_log();
    t0 = cyc;
    phase(4'b0001, 2'b00, 6);
    phase(4'b0001, 2'b10, 6);
    phase(4'b0001, 2'b01, 6);
    phase(4'b0001, 2'b00, 6);
    check_val("err_nev", ev_n[0], 2);
    chk_ev("err_b1", 0, 0, EV_B1, t0 + 11);
    chk_ev("err_err", 0, 1, EV_ERR, t0 + 17);
    phase(4'b0001, 2'b11, 6);
    check_val("err_then_stop", ev_typ[0][2], EV_STOP);

    // Timeout: 17 edges after the Mark-1 filtered change (edge t0+10).
    clear_log();
    t0 = cyc;
    phase(4'b0001, 2'b00, 6);
    phase(4'b0001, 2'b10, 30);
    phase(4'b0001, 2'b11, 6);
    check_val("tout_nev", ev_n[0], 2);
    chk_ev("tout_b1", 0, 0, EV_B1, t0 + 11);
    chk_ev("tout_tout", 0, 1, EV_TOUT, t0 + 27);
    check_val("tout_cnt", n_tout[0], 1);

    // Filtered change on the terminal-count edge: transition wins.
    clear_log();
    t0 = cyc;
    phase(4'b0001, 2'b00, 6);
    phase(4'b0001, 2'b10, 16);
    phase(4'b0001, 2'b00, 6);
    phase(4'b0001, 2'b11, 6);
    check_val("coin_tout", n_tout[0], 0);
    check_val("coin_nev", ev_n[0], 2);
    chk_ev("coin_b1", 0, 0, EV_B1, t0 + 11);
    chk_ev("coin_stop", 0, 1, EV_STOP, t0 + 33);

    // Lane 2 disabled while lanes 1 and 2 carry the same traffic.
    lane_en = 4'b1011;
    clear_log();
    phase(4'b0110, 2'b00, 6);
    phase(4'b0110, 2'b10, 6);
    phase(4'b0110, 2'b00, 6);
    phase(4'b0110, 2'b01, 6);
    phase(4'b0110, 2'b00, 6);
    phase(4'b0110, 2'b11, 6);
    check_val("en_l2_nev", ev_n[2], 0);
    check_val("en_l2_nz", nz[2], 0);
    check_val("en_l1_nev", ev_n[1], 3);
    lane_en = '1;
    repeat (4) step();

    // Random multi-lane streams with random phase lengths of 3..6 cycles.
    for (int l = 0; l < NL; l++) begin
      for (int k = 0; k < NB; k++) exp_bit[l][k] = 1'($urandom_range(0, 1));
      ph_left[l] = 0;
      ph_idx[l]  = -1;
    end
    clear_log();
    done = 1'b0;
    while (!done) begin
      done = 1'b1;
      for (int l = 0; l < NL; l++) begin
        if (ph_left[l] == 0 && ph_idx[l] <= 2 * NB) begin
          ph_idx[l]++;
          if (ph_idx[l] == 2 * NB + 1) rv = 2'b11;
          else if (ph_idx[l] % 2 == 1) rv = exp_bit[l][ph_idx[l] / 2] ? 2'b10 : 2'b01;
          else rv = 2'b00;
          lp_rx_dp[l] = rv[1];
          lp_rx_dn[l] = rv[0];
          ph_left[l]  = $urandom_range(3, 6);
        end
        if (ph_idx[l] <= 2 * NB) done = 1'b0;
      end
      step();
      for (int l = 0; l < NL; l++) if (ph_left[l] > 0) ph_left[l]--;
    end
    repeat (10) step();
    for (int l = 0; l < NL; l++) begin
      check_val($sformatf("rnd_l%0d_nbits", l), got_n[l], NB);
      for (int k = 0; k < NB; k++)
        check_val($sformatf("rnd_l%0d_b%0d", l, k), int'(got_bit[l][k]), int'(exp_bit[l][k]));
      check_val($sformatf("rnd_l%0d_stop", l), n_stop[l], 1);
      check_val($sformatf("rnd_l%0d_err", l), n_err[l], 0);
      check_val($sformatf("rnd_l%0d_tout", l), n_tout[l], 0);
    end

    // Reset on the edge where a Mark-to-Mark error would have been strobed.
    clear_log();
    phase(4'b1111, 2'b00, 6);
    phase(4'b1111, 2'b10, 6);
    phase(4'b1111, 2'b01, 4);
    sys_rst = 1'b1;
    step();
    chk_outs_zero("midrst");
    sys_rst = 1'b0;
    phase(4'b1111, 2'b11, 10);
    sum = 0;
    for (int l = 0; l < NL; l++) begin
      check_val($sformatf("midrst_l%0d_nev", l), ev_n[l], 1);
      sum += n_err[l];
    end
    check_val("midrst_err", sum, 0);

    check_val("one_hot_strobes", n_multi, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
